// File: rtl/stopwatch_lap_timer_if.sv
// Lap FIFO read port of the stopwatch: pop strobe plus show-ahead head entry and fill status.
interface stopwatch_lap_timer_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic          lap_rd;
  logic [6:0]    lap_mins;
  logic [5:0]    lap_secs;
  logic [6:0]    lap_frac;
  logic [CW-1:0] lap_count;
  logic          lap_empty;
  logic          lap_full;

  modport master (
    output lap_rd,
    input  lap_mins, lap_secs, lap_frac, lap_count, lap_empty, lap_full
  );

  modport slave (
    input  lap_rd,
    output lap_mins, lap_secs, lap_frac, lap_count, lap_empty, lap_full
  );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch core: tick prescaler, up/down time counter, display hold, lap FIFO and panel blink.
// state | meaning
// IDLE  | cleared, waiting for the first start edge
// RUN   | prescaler counting, time advances on each tick
// PAUSE | prescaler and time frozen, start edge resumes
// DONE  | countdown reached 0:00:00, terminal until reset
// OVF   | count-up hit the rollover limit, terminal until reset
module stopwatch_lap_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int IND_HZ    = 1,
  parameter int MAX_MINS  = 99,
  parameter int LAP_DEPTH = 4
) (
  input  logic                  CLK_50MHz,
  input  logic                  reset_n,
  input  logic                  start_stop,
  input  logic                  hold,
  input  logic                  lap_n,
  input  logic                  count_down,
  input  logic [6:0]            preset_mins,
  input  logic [5:0]            preset_secs,
  stopwatch_lap_timer_if.slave  lap,
  output logic [6:0]            mins,
  output logic [5:0]            secs,
  output logic [6:0]            frac,
  output logic                  running,
  output logic                  overflow_flag,
  output logic                  done_flag,
  output logic                  CLK_ind
);

  localparam int PRE_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int IND_DIV = CLK_HZ / (2 * IND_HZ);
  localparam int IND_W   = (IND_DIV > 1) ? $clog2(IND_DIV) : 1;
  localparam int PW      = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW      = $clog2(LAP_DEPTH + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRE_DIV - 1);
  localparam logic [IND_W-1:0] IND_LAST  = IND_W'(IND_DIV - 1);
  localparam logic [PW-1:0]    PTR_LAST  = PW'(LAP_DEPTH - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(LAP_DEPTH);
  localparam logic [6:0]       FRAC_LAST = 7'(TICK_HZ - 1);
  localparam logic [6:0]       MINS_LAST = 7'(MAX_MINS);
  localparam logic [5:0]       SECS_LAST = 6'd59;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_OVF   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       ss_sync, lap_sync;
  logic [1:0]       hold_sync;
  logic             start_pulse, lap_pulse, hold_s;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick, cd_mode;
  logic [6:0]       live_mins, live_frac;
  logic [5:0]       live_secs;
  logic [6:0]       up_mins, up_frac, dn_mins, dn_frac, pre_m;
  logic [5:0]       up_secs, dn_secs, pre_s;
  logic             up_ovf, dn_zero;
  logic [IND_W-1:0] ind_cnt;
  logic [19:0]      mem [LAP_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_clr, do_push, do_pop;

  // Bit 0 is the first synchroniser flop, bit 2 the history flop.
  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      ss_sync   <= 3'b111;
      lap_sync  <= 3'b111;
      hold_sync <= 2'b11;
    end else begin
      ss_sync   <= {ss_sync[1:0], start_stop};
      lap_sync  <= {lap_sync[1:0], lap_n};
      hold_sync <= {hold_sync[0], hold};
    end
  end

  assign start_pulse = ss_sync[2] & ~ss_sync[1];
  assign lap_pulse   = lap_sync[2] & ~lap_sync[1];
  assign hold_s      = hold_sync[1];
  assign tick        = (state == ST_RUN) && (pre_cnt == PRE_LAST);

  assign pre_m = (preset_mins > MINS_LAST) ? MINS_LAST : preset_mins;
  assign pre_s = (preset_secs > SECS_LAST) ? SECS_LAST : preset_secs;

  always_comb begin
    up_mins = live_mins;
    up_secs = live_secs;
    up_frac = live_frac;
    up_ovf  = 1'b0;
    if (live_frac != FRAC_LAST) begin
      up_frac = live_frac + 7'd1;
    end else if (live_secs != SECS_LAST) begin
      up_frac = '0;
      up_secs = live_secs + 6'd1;
    end else if (live_mins != MINS_LAST) begin
      up_frac = '0;
      up_secs = '0;
      up_mins = live_mins + 7'd1;
    end else begin
      up_ovf = 1'b1;
    end
  end

  always_comb begin
    dn_mins = live_mins;
    dn_secs = live_secs;
    dn_frac = live_frac;
    if (live_frac != 7'd0) begin
      dn_frac = live_frac - 7'd1;
    end else begin
      dn_frac = FRAC_LAST;
      if (live_secs != 6'd0) begin
        dn_secs = live_secs - 6'd1;
      end else begin
        dn_secs = SECS_LAST;
        dn_mins = live_mins - 7'd1;
      end
    end
    dn_zero = (dn_mins == 7'd0) && (dn_secs == 6'd0) && (dn_frac == 7'd0);
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pre_cnt       <= '0;
      cd_mode       <= 1'b0;
      live_mins     <= '0;
      live_secs     <= '0;
      live_frac     <= '0;
      running       <= 1'b0;
      overflow_flag <= 1'b0;
      done_flag     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_pulse) begin
            pre_cnt   <= '0;
            cd_mode   <= count_down;
            live_frac <= '0;
            if (count_down) begin
              live_mins <= pre_m;
              live_secs <= pre_s;
              if (pre_m == 7'd0 && pre_s == 6'd0) begin
                state     <= ST_DONE;
                done_flag <= 1'b1;
              end else begin
                state   <= ST_RUN;
                running <= 1'b1;
              end
            end else begin
              live_mins <= '0;
              live_secs <= '0;
              state     <= ST_RUN;
              running   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
          // A terminal tick wins over a simultaneous start edge.
          if (tick && !cd_mode && up_ovf) begin
            state         <= ST_OVF;
            running       <= 1'b0;
            overflow_flag <= 1'b1;
          end else if (tick && cd_mode && dn_zero) begin
            live_mins <= dn_mins;
            live_secs <= dn_secs;
            live_frac <= dn_frac;
            state     <= ST_DONE;
            running   <= 1'b0;
            done_flag <= 1'b1;
          end else begin
            if (tick) begin
              live_mins <= cd_mode ? dn_mins : up_mins;
              live_secs <= cd_mode ? dn_secs : up_secs;
              live_frac <= cd_mode ? dn_frac : up_frac;
            end
            if (start_pulse) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (start_pulse) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_DONE, ST_OVF: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      mins <= '0;
      secs <= '0;
      frac <= '0;
    end else if (hold_s) begin
      mins <= live_mins;
      secs <= live_secs;
      frac <= live_frac;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      ind_cnt <= IND_LAST;
      CLK_ind <= 1'b0;
    end else if (ind_cnt == '0) begin
      ind_cnt <= IND_LAST;
      CLK_ind <= ~CLK_ind;
    end else begin
      ind_cnt <= ind_cnt - IND_W'(1);
    end
  end

  // A full FIFO still accepts a push when the same edge frees a slot.
  assign fifo_clr = (state == ST_IDLE) && start_pulse;
  assign do_pop   = lap.lap_rd && (count != '0);
  assign do_push  = lap_pulse && (state != ST_IDLE) && ((count != DEPTH_C) || do_pop);

  always_ff @(posedge CLK_50MHz) begin
    if (do_push) begin
      mem[wr_ptr] <= {live_mins, live_secs, live_frac};
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!reset_n || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign lap.lap_count = count;
  assign lap.lap_empty = (count == '0);
  assign lap.lap_full  = (count == DEPTH_C);
  assign {lap.lap_mins, lap.lap_secs, lap.lap_frac} = (count == '0) ? 20'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench: a 10-cycle-tick instance for the main scenarios and a 2-cycle-tick one for overflow.
module tb_stopwatch_lap_timer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int now_c = 0;
  always @(posedge clk) now_c <= now_c + 1;

  int checks = 0;
  int failures = 0;

  // Instance A: CLK_HZ=1000, TICK_HZ=100, IND_HZ=50, MAX_MINS=1, LAP_DEPTH=2
  logic       a_rst_n, a_ss, a_hold, a_lap, a_cd;
  logic [6:0] a_pm, a_mins, a_frac;
  logic [5:0] a_ps, a_secs;
  logic       a_run, a_ovf, a_done, a_ind;
  stopwatch_lap_timer_if #(.LAP_DEPTH(2)) lap_a ();

  stopwatch_lap_timer #(
    .CLK_HZ(1000), .TICK_HZ(100), .IND_HZ(50), .MAX_MINS(1), .LAP_DEPTH(2)
  ) dut_a (
    .CLK_50MHz(clk), .reset_n(a_rst_n), .start_stop(a_ss), .hold(a_hold), .lap_n(a_lap),
    .count_down(a_cd), .preset_mins(a_pm), .preset_secs(a_ps), .lap(lap_a),
    .mins(a_mins), .secs(a_secs), .frac(a_frac), .running(a_run),
    .overflow_flag(a_ovf), .done_flag(a_done), .CLK_ind(a_ind)
  );

  // Instance B: CLK_HZ=20, TICK_HZ=10, IND_HZ=5, MAX_MINS=1, LAP_DEPTH=1
  logic       b_rst_n, b_ss, b_hold, b_lap, b_cd;
  logic [6:0] b_pm, b_mins, b_frac;
  logic [5:0] b_ps, b_secs;
  logic       b_run, b_ovf, b_done, b_ind;
  stopwatch_lap_timer_if #(.LAP_DEPTH(1)) lap_b ();

  stopwatch_lap_timer #(
    .CLK_HZ(20), .TICK_HZ(10), .IND_HZ(5), .MAX_MINS(1), .LAP_DEPTH(1)
  ) dut_b (
    .CLK_50MHz(clk), .reset_n(b_rst_n), .start_stop(b_ss), .hold(b_hold), .lap_n(b_lap),
    .count_down(b_cd), .preset_mins(b_pm), .preset_secs(b_ps), .lap(lap_b),
    .mins(b_mins), .secs(b_secs), .frac(b_frac), .running(b_run),
    .overflow_flag(b_ovf), .done_flag(b_done), .CLK_ind(b_ind)
  );

  int   ind_toggles = 0;
  logic ind_last = 1'b0;
  always @(negedge clk) begin
    if (a_ind !== ind_last) begin
      ind_toggles <= ind_toggles + 1;
      ind_last    <= a_ind;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tv(input logic [6:0] m, input logic [5:0] s, input logic [6:0] f);
    return int'(m) * 10000 + int'(s) * 100 + int'(f);
  endfunction

  // Leaves the bench 1 time unit after posedge number 'target'.
  task automatic goto(input int target);
    while (now_c < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    goto(now_c + n);
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    step(2);
    a_rst_n = 1'b1;
    step(1);
  endtask

  // Returns the edge on which the start press acts; the button is released afterwards.
  task automatic press_a(output int base);
    int t;
    t = now_c;
    a_ss = 1'b0;
    goto(t + 3);
    base = t + 3;
    a_ss = 1'b1;
  endtask

  task automatic press_b(output int base);
    int t;
    t = now_c;
    b_ss = 1'b0;
    goto(t + 3);
    base = t + 3;
    b_ss = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, i0;
    a_rst_n = 1'b0; a_ss = 1'b1; a_hold = 1'b1; a_lap = 1'b1; a_cd = 1'b0;
    a_pm = '0; a_ps = '0; lap_a.lap_rd = 1'b0;
    b_rst_n = 1'b0; b_ss = 1'b1; b_hold = 1'b1; b_lap = 1'b1; b_cd = 1'b0;
    b_pm = '0; b_ps = '0; lap_b.lap_rd = 1'b0;
    @(posedge clk);
    #1;
    step(2);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    step(1);

    check("rst_disp", tv(a_mins, a_secs, a_frac), 0);
    check("rst_running", int'(a_run), 0);
    check("rst_flags", int'({a_ovf, a_done}), 0);
    check("rst_ind", int'(a_ind), 0);
    check("rst_lap_count", int'(lap_a.lap_count), 0);
    check("rst_lap_empty_full", int'({lap_a.lap_empty, lap_a.lap_full}), 2);

    // Count-up for one second; blink toggles every 10 cycles
    press_a(base);
    check("up_running", int'(a_run), 1);
    i0 = ind_toggles;
    goto(base + 1000);
    check("up_0_00_99", tv(a_mins, a_secs, a_frac), tv(7'd0, 6'd0, 7'd99));
    check("ind_toggles", ind_toggles - i0, 100);
    goto(base + 1001);
    check("up_0_01_00", tv(a_mins, a_secs, a_frac), tv(7'd0, 6'd1, 7'd0));
    check("up_still_running", int'(a_run), 1);

    // Pause at 37 cycles into RUN, resume after 500; prescaler phase preserved
    reset_a();
    press_a(base);
    goto(base + 34);
    a_ss = 1'b0;
    goto(base + 37);
    check("pause_running", int'(a_run), 0);
    check("pause_disp", tv(a_mins, a_secs, a_frac), 3);
    a_ss = 1'b1;
    goto(base + 537);
    check("pause_frozen", tv(a_mins, a_secs, a_frac), 3);
    a_ss = 1'b0;
    goto(base + 540);
    check("resume_running", int'(a_run), 1);
    a_ss = 1'b1;
    goto(base + 543);
    check("resume_pre_tick", tv(a_mins, a_secs, a_frac), 3);
    goto(base + 544);
    check("resume_tick_3", tv(a_mins, a_secs, a_frac), 4);

    // Display hold during RUN
    reset_a();
    press_a(base);
    goto(base + 100);
    a_hold = 1'b0;
    goto(base + 250);
    check("hold_frozen_a", tv(a_mins, a_secs, a_frac), 10);
    goto(base + 400);
    check("hold_frozen_b", tv(a_mins, a_secs, a_frac), 10);
    a_hold = 1'b1;
    goto(base + 402);
    check("hold_release_edge", tv(a_mins, a_secs, a_frac), 10);
    goto(base + 403);
    check("hold_release_live", tv(a_mins, a_secs, a_frac), 40);

    // Count-down from 0:01
    reset_a();
    a_cd = 1'b1; a_pm = 7'd0; a_ps = 6'd1;
    press_a(base);
    check("dn_running", int'(a_run), 1);
    goto(base + 10);
    check("dn_loaded", tv(a_mins, a_secs, a_frac), tv(7'd0, 6'd1, 7'd0));
    goto(base + 999);
    check("dn_0_00_01", tv(a_mins, a_secs, a_frac), 1);
    check("dn_not_done", int'(a_done), 0);
    goto(base + 1000);
    check("dn_done", int'(a_done), 1);
    check("dn_stopped", int'(a_run), 0);
    goto(base + 1001);
    check("dn_zero", tv(a_mins, a_secs, a_frac), 0);
    a_ss = 1'b0;
    goto(base + 1005);
    a_ss = 1'b1;
    goto(base + 1010);
    check("done_ignores_start", int'({a_run, a_done}), 1);

    // Preset saturation 127:63 -> 1:59
    reset_a();
    a_pm = 7'd127; a_ps = 6'd63;
    press_a(base);
    goto(base + 1);
    check("sat_loaded", tv(a_mins, a_secs, a_frac), tv(7'd1, 6'd59, 7'd0));
    goto(base + 11);
    check("sat_borrow", tv(a_mins, a_secs, a_frac), tv(7'd1, 6'd58, 7'd99));

    // Preset 0:00 goes straight to DONE
    reset_a();
    a_pm = 7'd0; a_ps = 6'd0;
    press_a(base);
    check("zero_preset_done", int'(a_done), 1);
    check("zero_preset_run", int'(a_run), 0);
    a_cd = 1'b0;

    // Lap FIFO, depth 2
    reset_a();
    a_lap = 1'b0;
    step(4);
    check("lap_idle_ignored", int'(lap_a.lap_count), 0);
    a_lap = 1'b1;
    step(4);
    press_a(base);
    goto(base + 21);  a_lap = 1'b0;
    goto(base + 24);  a_lap = 1'b1;
    goto(base + 47);  a_lap = 1'b0;
    goto(base + 50);  a_lap = 1'b1;
    check("lap_two_full", int'({lap_a.lap_count, lap_a.lap_full}), 5);
    goto(base + 60);  a_lap = 1'b0;
    goto(base + 63);  a_lap = 1'b1;
    goto(base + 64);
    check("lap_drop_count", int'(lap_a.lap_count), 2);
    check("lap_drop_flags", int'({lap_a.lap_empty, lap_a.lap_full}), 1);
    check("lap_head_first", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 2);
    goto(base + 80);  a_lap = 1'b0;
    goto(base + 82);  lap_a.lap_rd = 1'b1;
    goto(base + 83);  lap_a.lap_rd = 1'b0; a_lap = 1'b1;
    check("lap_pushpop_count", int'(lap_a.lap_count), 2);
    check("lap_pushpop_head", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 4);
    goto(base + 90);  lap_a.lap_rd = 1'b1;
    goto(base + 91);  lap_a.lap_rd = 1'b0;
    check("lap_pop1_count", int'({lap_a.lap_count, lap_a.lap_full}), 2);
    check("lap_pop1_head", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 8);
    goto(base + 95);  lap_a.lap_rd = 1'b1;
    goto(base + 96);  lap_a.lap_rd = 1'b0;
    check("lap_pop2_empty", int'({lap_a.lap_count, lap_a.lap_empty}), 1);
    check("lap_pop2_head", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 0);
    goto(base + 100); lap_a.lap_rd = 1'b1;
    goto(base + 101); lap_a.lap_rd = 1'b0;
    check("lap_pop_empty", int'({lap_a.lap_count, lap_a.lap_empty}), 1);
    goto(base + 110); a_lap = 1'b0;
    goto(base + 113); a_lap = 1'b1;
    goto(base + 114);
    check("lap_push_again", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 11);

    // Reset mid-run with a FIFO entry pending
    a_rst_n = 1'b0;
    goto(base + 115);
    check("midrst_disp", tv(a_mins, a_secs, a_frac), 0);
    check("midrst_status", int'({a_run, a_ovf, a_done, a_ind}), 0);
    check("midrst_lap_count", int'(lap_a.lap_count), 0);
    check("midrst_lap_flags", int'({lap_a.lap_empty, lap_a.lap_full}), 2);
    check("midrst_lap_head", tv(lap_a.lap_mins, lap_a.lap_secs, lap_a.lap_frac), 0);
    a_rst_n = 1'b1;

    // Overflow at 1:59:9 on the fast instance
    b_rst_n = 1'b0;
    step(2);
    b_rst_n = 1'b1;
    step(1);
    press_b(base);
    check("ovf_running", int'(b_run), 1);
    goto(base + 2399);
    check("ovf_last_time", tv(b_mins, b_secs, b_frac), tv(7'd1, 6'd59, 7'd9));
    check("ovf_not_yet", int'(b_ovf), 0);
    goto(base + 2400);
    check("ovf_flag", int'(b_ovf), 1);
    check("ovf_stopped", int'(b_run), 0);
    goto(base + 2401);
    check("ovf_time_held", tv(b_mins, b_secs, b_frac), tv(7'd1, 6'd59, 7'd9));
    b_ss = 1'b0;
    goto(base + 2404); b_ss = 1'b1;
    goto(base + 2410);
    check("ovf_ignores_start", int'({b_run, b_ovf}), 1);
    check("ovf_time_after_start", tv(b_mins, b_secs, b_frac), tv(7'd1, 6'd59, 7'd9));
    b_lap = 1'b0;
    goto(base + 2413); b_lap = 1'b1;
    goto(base + 2414);
    check("ovf_lap_count", int'({lap_b.lap_count, lap_b.lap_full}), 3);
    check("ovf_lap_head", tv(lap_b.lap_mins, lap_b.lap_secs, lap_b.lap_frac), tv(7'd1, 6'd59, 7'd9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap_timer.md
# stopwatch_lap_timer

Parametrised single-clock stopwatch core: the next generation of the board stopwatch. It replaces the divided 100 Hz clock with an internal clock-enable tick and adds count-up/count-down modes, a lap-capture FIFO and configurable rollover limits. It sits between the pushbutton inputs and the seven-segment encoder, which consumes `mins`/`secs`/`frac` as binary fields. The panel indicator blink is generated here.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; must be a multiple of `TICK_HZ` and of 2*`IND_HZ`.
- `TICK_HZ`, 100, sub-second resolution; `frac` counts 0..`TICK_HZ`-1; legal range 2..100.
- `IND_HZ`, 1, `CLK_ind` square-wave frequency.
- `MAX_MINS`, 99, last minute value before overflow; legal range 1..127.
- `LAP_DEPTH`, 4, lap FIFO entries; must be at least 1.
- `CLK_50MHz` in 1: the single clock. All logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start_stop` in 1: active-low button. Its falling edge toggles run/pause.
- `hold` in 1: active-low level. While low, the display outputs freeze and timing continues (split).
- `lap_n` in 1: active-low button. Its falling edge captures the live time into the lap FIFO.
- `count_down` in 1: mode select, 1 = count down. Sampled only on the IDLE→RUN transition.
- `preset_mins` in 7 / `preset_secs` in 6: countdown start value. Loaded on IDLE→RUN when `count_down`=1.
- `lap_rd` in 1: active-high pop of the lap FIFO head.
- `mins` out 7, `secs` out 6, `frac` out 7: displayed time.
- `lap_mins` out 7, `lap_secs` out 6, `lap_frac` out 7: FIFO head (show-ahead). Zero when empty.
- `lap_count` out $clog2(`LAP_DEPTH`+1): number of entries in the FIFO.
- `lap_empty`, `lap_full` out 1: FIFO status flags.
- `running` out 1: high in RUN.
- `overflow_flag` out 1: count-up limit reached.
- `done_flag` out 1: countdown reached zero.
- `CLK_ind` out 1: free-running blink, toggling every `CLK_HZ`/(2*`IND_HZ`) cycles.

## Operation
- Buttons: each of `start_stop` and `lap_n` passes through a 2-flop synchroniser plus a history flop. All three flops reset to 1. An edge pulse fires when the history flop is 1 and the synchroniser output is 0. A held button produces exactly one pulse.
- States: IDLE, RUN, PAUSE, DONE, OVF.
  - IDLE + start edge → RUN. The time is cleared and the FIFO is emptied.
  - In count-down mode, IDLE + start edge loads the preset instead; `preset_secs` values above 59 saturate to 59, and `preset_mins` values above `MAX_MINS` saturate to `MAX_MINS`.
  - A preset of 0:00 goes directly to DONE with `done_flag`=1.
  - RUN + start edge → PAUSE. PAUSE + start edge → RUN.
  - DONE and OVF ignore start edges. Only `reset_n` exits any state back to IDLE.
- Prescaler: counts 0..`CLK_HZ`/`TICK_HZ`-1 only in RUN and emits a one-cycle tick at the terminal count. It holds its value in PAUSE, so the fraction is preserved across a pause. It clears on reset and on IDLE→RUN.
- Count up, on each tick: `frac`+1. Wrap `TICK_HZ`-1→0 carries into secs. Wrap 59→0 carries into mins.
  - A tick at `MAX_MINS`:59:`TICK_HZ`-1 does not wrap. The time holds, `overflow_flag` is set and the state moves to OVF.
- Count down, on each tick: decrement with borrows. The tick that makes the time 0:00:00 also sets `done_flag` and moves the state to DONE.
- Display: the `mins`/`secs`/`frac` registers copy the live time every cycle while the synchronised `hold` is 1, and hold their value while it is 0.
- Lap FIFO:
  - A lap edge in RUN, PAUSE, DONE or OVF pushes the live time. Lap edges in IDLE are ignored.
  - A push when full is dropped; the existing contents are kept.
  - A `lap_rd` pop when empty is ignored.
  - A simultaneous push and pop when full performs both, so the count is unchanged.
- Reset values:
  - All time, display and lap outputs are 0; `lap_count`=0, `lap_empty`=1, `lap_full`=0.
  - `running`, `overflow_flag`, `done_flag` and `CLK_ind` are 0; the state is IDLE.

## Timing
- A button's falling edge affects the state and time registers at the 3rd rising clock edge after the pin is first sampled low.
- Tick → live time update on the same edge. Live time → display output one cycle later.
- A tick and a start edge in the same cycle: the tick is applied first, then the state changes.
- A lap push captures the live time registered before that cycle's tick update.
- `lap_rd` takes effect on the next edge. The new head is visible in the following cycle.
- A `reset_n` low sample at any edge, including mid-run or mid-FIFO-operation, fully reinitialises the block on that edge. This includes the `CLK_ind` counter and the synchronisers.
- Flags assert in the same cycle as the state entry and are registered.

## Test plan
- Parameters `CLK_HZ`=1000, `TICK_HZ`=100, `IND_HZ`=50, `MAX_MINS`=1, count-up. Press start, wait 1000 cycles → time 0:01:00, `running`=1, `CLK_ind` toggled 100 times.
- Run to 1:59:99, then one more tick → time holds 1:59:99, `overflow_flag`=1. A subsequent start edge is ignored.
- Count-down, preset 0:01. Start, wait 1000 cycles → 0:00:00, `done_flag`=1, state DONE.
- Count-down, preset 0:00. Start → DONE in the same cycle as RUN would have been entered.
- Pause after 37 cycles, wait 500 cycles, resume → the next tick arrives after 10-(37 mod 10) = 3 cycles.
- `LAP_DEPTH`=2. Press lap three times → `lap_count`=2, `lap_full`=1, the head is the first capture. Pop twice → `lap_empty`=1 and the lap outputs are 0.
- Hold low for 300 cycles during RUN → display frozen. Release → display matches live time one cycle later.
- Assert `reset_n` mid-run → all outputs at their reset values on the next edge.
